pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl_hazard_detect.sv | 32 +++
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline controller
// Purpose: FSM state encoding, default memory timeout, register-address and
//          wait-counter widths used by pipe_ctrl and hazard_detect.
// Ports:   none (package)
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W          = 5;
  localparam int unsigned WAIT_CNT_W          = 8;
  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
  localparam int unsigned STALL_CNT_W         = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use hazard compare
// Purpose: flags a load in EX whose destination feeds a source operand of
//          the instruction in ID. A pending memory stall masks the hazard
//          because the whole pipe is frozen anyway.
// Ports:   mem_stall_i       - memory stall active this cycle
//          idex_memread_i    - load occupies EX
//          idex_rdaddr_i     - EX destination register
//          ifid_rs1addr_i    - ID source register 1
//          ifid_rs2addr_i    - ID source register 2
//          load_use_o        - load-use hazard present
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  mem_stall_i,
  input  logic                  idex_memread_i,
  input  logic [REG_ADDR_W-1:0] idex_rdaddr_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs1addr_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs2addr_i,
  output logic                  load_use_o
);

  logic rd_nonzero;
  logic rd_match;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign rd_nonzero = (idex_rdaddr_i != '0);
  assign rd_match   = (idex_rdaddr_i == ifid_rs1addr_i) ||
                      (idex_rdaddr_i == ifid_rs2addr_i);

  assign load_use_o = !mem_stall_i && idex_memread_i && rd_nonzero && rd_match;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard and memory-wait controller
// Purpose: three-state FSM (IDLE/RUN/MEM_WAIT) producing PC-write, stall,
//          flush and bubble controls with priority mem_stall > load_use >
//          branch, a saturating memory-wait counter with sticky timeout flag,
//          and an optional stall-cycle counter.
// Build option: PIPE_CTRL_STALL_CNT_EN builds the 32-bit stall counter;
//          without it stall_cnt_o is tied to zero.
// Ports:   clk_i                      - clock, rising edge
//          rst_i                      - asynchronous reset, active low
//          start_i                    - run enable
//          IDEX_MemRead_i/RDaddr_i    - load in EX and its destination
//          IFID_RS1addr_i/RS2addr_i   - ID-stage source registers
//          branch_taken_i             - branch resolved taken in ID
//          mem_req_i / mem_ack_i      - data-memory request / completion
//          PCWrite_o                  - PC may update
//          IFID/IDEX/EXMEM/MEMWB_stall_o - hold pipeline registers
//          IFID_flush_o               - zero IF/ID instruction
//          bubble_o                   - zero control into ID/EX
//          err_o                      - sticky memory timeout (registered)
//          stall_cnt_o                - stall cycle count (registered)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   IDEX_MemRead_i,
  input  logic [REG_ADDR_W-1:0]  IDEX_RDaddr_i,
  input  logic [REG_ADDR_W-1:0]  IFID_RS1addr_i,
  input  logic [REG_ADDR_W-1:0]  IFID_RS2addr_i,
  input  logic                   branch_taken_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ack_i,
  output logic                   PCWrite_o,
  output logic                   IFID_stall_o,
  output logic                   IDEX_stall_o,
  output logic                   EXMEM_stall_o,
  output logic                   MEMWB_stall_o,
  output logic                   IFID_flush_o,
  output logic                   bubble_o,
  output logic                   err_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(MEM_TIMEOUT);

  state_e                 state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                   err_q, err_d;
  logic                   mem_stall;
  logic                   load_use;

  assign mem_stall = (state_q != IDLE) && mem_req_i && !mem_ack_i;

  hazard_detect u_hazard_detect (
    .mem_stall_i    (mem_stall),
    .idex_memread_i (IDEX_MemRead_i),
    .idex_rdaddr_i  (IDEX_RDaddr_i),
    .ifid_rs1addr_i (IFID_RS1addr_i),
    .ifid_rs2addr_i (IFID_RS2addr_i),
    .load_use_o     (load_use)
  );

  // Next state and combinational pipeline controls
  always_comb begin
    state_d       = state_q;
    PCWrite_o     = 1'b1;
    IFID_stall_o  = 1'b0;
    IDEX_stall_o  = 1'b0;
    EXMEM_stall_o = 1'b0;
    MEMWB_stall_o = 1'b0;
    IFID_flush_o  = 1'b0;
    bubble_o      = 1'b0;

    unique case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          PCWrite_o     = 1'b0;
          IFID_stall_o  = 1'b1;
          IDEX_stall_o  = 1'b1;
          EXMEM_stall_o = 1'b1;
          MEMWB_stall_o = 1'b1;
          state_d       = MEM_WAIT;
        end else begin
          state_d = RUN;
          if (load_use) begin
            // Hold IF/ID and PC, let EX onward drain while a bubble enters EX
            PCWrite_o    = 1'b0;
            IFID_stall_o = 1'b1;
            bubble_o     = 1'b1;
          end else if (branch_taken_i) begin
            IFID_flush_o = 1'b1;
          end
        end
      end
      default: begin
        PCWrite_o     = 1'b0;
        IFID_stall_o  = 1'b1;
        IDEX_stall_o  = 1'b1;
        EXMEM_stall_o = 1'b1;
        MEMWB_stall_o = 1'b1;
        state_d       = start_i ? RUN : IDLE;
      end
    endcase

    // Dropping run enable parks the pipe from any state
    if (!start_i) begin
      state_d = IDLE;
    end
  end

  // Wait counter: cleared on the RUN->MEM_WAIT stall cycle, then counts
  // every further stalled cycle spent in MEM_WAIT, holding at the timeout
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == RUN && mem_stall) begin
      wait_cnt_d = '0;
    end else if (state_q == MEM_WAIT && mem_stall && wait_cnt_q != TIMEOUT_CNT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    err_d = err_q || (wait_cnt_d == TIMEOUT_CNT);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Any active-state cycle that blocks the PC counts as a stall; wraps freely
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q != IDLE && !PCWrite_o) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int unsigned TMO = 4;

`ifdef PIPE_CTRL_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_i = 1'b1;
  logic        rst_i;
  logic        start_i;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RDaddr_i;
  logic [4:0]  IFID_RS1addr_i;
  logic [4:0]  IFID_RS2addr_i;
  logic        branch_taken_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        PCWrite_o;
  logic        IFID_stall_o;
  logic        IDEX_stall_o;
  logic        EXMEM_stall_o;
  logic        MEMWB_stall_o;
  logic        IFID_flush_o;
  logic        bubble_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;

  // negedge at 5, posedge at 10: inputs change at posedge+1, checks at negedge
  always #5 clk_i = ~clk_i;

  pipe_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RDaddr_i  (IDEX_RDaddr_i),
    .IFID_RS1addr_i (IFID_RS1addr_i),
    .IFID_RS2addr_i (IFID_RS2addr_i),
    .branch_taken_i (branch_taken_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .PCWrite_o      (PCWrite_o),
    .IFID_stall_o   (IFID_stall_o),
    .IDEX_stall_o   (IDEX_stall_o),
    .EXMEM_stall_o  (EXMEM_stall_o),
    .MEMWB_stall_o  (MEMWB_stall_o),
    .IFID_flush_o   (IFID_flush_o),
    .bubble_o       (bubble_o),
    .err_o          (err_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  // ctrl = {PCWrite, IFID, IDEX, EXMEM, MEMWB stalls, flush, bubble}
  typedef struct packed {
    logic [6:0]  ctrl;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: running flag, waiting flag, consecutive wait count
  bit          m_running;
  bit          m_waiting;
  int          m_waits;
  bit          m_err;
  logic [31:0] m_stalls;

  task automatic model_reset();
    m_running = 0;
    m_waiting = 0;
    m_waits   = 0;
    m_err     = 0;
    m_stalls  = 32'd0;
  endtask

  function automatic bit mem_blocked();
    return m_running && mem_req_i && !mem_ack_i;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit   lu;
    lu = !mem_blocked() && IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
         (IDEX_RDaddr_i == IFID_RS1addr_i || IDEX_RDaddr_i == IFID_RS2addr_i);
    if (!m_running || mem_blocked()) e.ctrl = 7'b0_1111_00;
    else if (lu)                     e.ctrl = 7'b0_1000_01;
    else if (branch_taken_i)         e.ctrl = 7'b1_0000_10;
    else                             e.ctrl = 7'b1_0000_00;
    e.err = m_err;
    e.cnt = CNT_EN ? m_stalls : 32'd0;
    return e;
  endfunction

  task automatic model_step(input exp_t e);
    bit blk;
    if (!rst_i) return;
    blk = mem_blocked();
    if (m_running && !e.ctrl[6]) m_stalls = m_stalls + 32'd1;
    if (m_running && !m_waiting && blk)                       m_waits = 0;
    else if (m_running && m_waiting && blk && m_waits < TMO)  m_waits = m_waits + 1;
    if (m_waits == TMO) m_err = 1;
    if (!start_i)        begin m_running = 0; m_waiting = 0; end
    else if (!m_running) m_running = 1;
    else                 m_waiting = blk;
  endtask

  task automatic set_in(input int st, input int mr, input int rd, input int rs1,
                        input int rs2, input int br, input int rq, input int ak);
    start_i        = (st != 0);
    IDEX_MemRead_i = (mr != 0);
    IDEX_RDaddr_i  = 5'(rd);
    IFID_RS1addr_i = 5'(rs1);
    IFID_RS2addr_i = 5'(rs2);
    branch_taken_i = (br != 0);
    mem_req_i      = (rq != 0);
    mem_ack_i      = (ak != 0);
  endtask

  task automatic finish_cycle();
    exp_t e;
    if (!rst_i) model_reset();
    e = model_out();
    exp_q.push_back(e);
    @(posedge clk_i);
    model_step(e);
    #1;
  endtask

  task automatic cyc(input int st, input int mr, input int rd, input int rs1,
                     input int rs2, input int br, input int rq, input int ak);
    set_in(st, mr, rd, rs1, rs2, br, rq, ak);
    finish_cycle();
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT drives a fresh control word; compare it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl", 32'({PCWrite_o, IFID_stall_o, IDEX_stall_o, EXMEM_stall_o,
                         MEMWB_stall_o, IFID_flush_o, bubble_o}), 32'(e.ctrl));
        chk("err", 32'(err_o), 32'(e.err));
        chk("stall_cnt", stall_cnt_o, e.cnt);
      end
    end
  end

  initial begin
    int st, mr, rd, rs1, rs2, br, rq, ak;
    rst_i = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    // Held in reset even with start high
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 5, 5, 5, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);       // IDLE->RUN edge
    run_n(2);
    // load rd=x5, rs2=x5 -> one stall then normal
    cyc(1, 1, 5, 3, 5, 0, 0, 0);
    cyc(1, 0, 0, 3, 5, 0, 0, 0);
    // load to x0 with rs1=x0 -> no stall
    cyc(1, 1, 0, 0, 7, 0, 0, 0);
    // branch coincident with load-use, then branch alone
    cyc(1, 1, 9, 9, 2, 1, 0, 0);
    cyc(1, 0, 0, 9, 2, 1, 0, 0);
    run_n(1);
    // memory wait of 3 cycles then ack
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    run_n(2);
    // ack withheld 10 cycles -> timeout, flag sticky after ack
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    run_n(3);
    // reset mid MEM_WAIT, asserted between edges
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    set_in(1, 0, 0, 0, 0, 0, 1, 0);
    #2;
    rst_i = 1'b0;
    finish_cycle();
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    rst_i = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    run_n(2);
    // randomized traffic with small register indices to force matches
    for (int i = 0; i < 1500; i++) begin
      st  = ($urandom_range(0, 31) != 0) ? 1 : 0;
      mr  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rd  = int'($urandom_range(0, 7));
      rs1 = int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      br  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rq  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      ak  = ($urandom_range(0, 1) == 0) ? 1 : 0;
      cyc(st, mr, rd, rs1, rs2, br, rq, ak);
    end
    @(negedge clk_i);
    #1;
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
